// File: rtl/predictor_update_arbiter.sv
// ---------------------------------------------------------------------------
// predictor_update_arbiter
//
// Shares the branch predictor's single access port between fetch-side
// prediction lookups and commit-side outcome updates. Committed outcomes are
// queued in a small FIFO. Each cycle at most one requester owns the port.
// Fetch normally wins. A starvation/occupancy guard forces a feedback drain
// when either of these holds:
//   - fetch has been granted STARVE_LIMIT times in a row over a non-empty
//     queue, or
//   - the queue is one entry from full.
//
// Ports
//   Sys_clk              clock, all state on rising edge
//   Sys_rst              synchronous active-high reset
//   Sys_rdy              global enable; low freezes all state and grants
//   IFPA_predict_req     fetch lookup request (held until granted)
//   IFPA_pc              lookup PC
//   PAIF_predict_valid   prediction granted this cycle
//   PAIF_predict_result  predictor answer, gated by the grant
//   ROBPA_fb_valid       push one committed outcome
//   ROBPA_fb_pc          committed branch PC
//   ROBPA_fb_taken       committed branch outcome
//   PAROB_fb_full        queue full (registered)
//   PAPD_predict_en      predictor lookup enable
//   PAPD_pc              lookup PC passthrough
//   PDPA_predict_result  predictor combinational answer
//   PAPD_feedback_en     predictor update enable
//   PAPD_feedback_pc     queue head PC (0 when empty)
//   PAPD_branch_result   queue head outcome (0 when empty)
// ---------------------------------------------------------------------------
module predictor_update_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFPA_predict_req,
  input  logic [ADDR_WIDTH-1:0] IFPA_pc,
  output logic                  PAIF_predict_valid,
  output logic                  PAIF_predict_result,
  input  logic                  ROBPA_fb_valid,
  input  logic [ADDR_WIDTH-1:0] ROBPA_fb_pc,
  input  logic                  ROBPA_fb_taken,
  output logic                  PAROB_fb_full,
  output logic                  PAPD_predict_en,
  output logic [ADDR_WIDTH-1:0] PAPD_pc,
  input  logic                  PDPA_predict_result,
  output logic                  PAPD_feedback_en,
  output logic [ADDR_WIDTH-1:0] PAPD_feedback_pc,
  output logic                  PAPD_branch_result
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] DEPTH_C    = (FIFO_DEPTH_LOG+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0] NEAR_FULL  = (FIFO_DEPTH_LOG+1)'(DEPTH - 1);
  localparam logic [3:0]              STARVE_MAX = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
  } fb_entry_t;

  fb_entry_t                 mem_q [DEPTH];
  fb_entry_t                 mem_d [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] head_q, head_d;
  logic [FIFO_DEPTH_LOG-1:0] tail_q, tail_d;
  logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
  logic [3:0]                starve_q, starve_d;
  logic                      full_q, full_d;

  logic      active;
  logic      fifo_nonempty;
  logic      force_fb;
  logic      predict_gnt;
  logic      feedback_gnt;
  logic      push;
  logic      pop;
  fb_entry_t head_entry;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    active        = Sys_rdy && !Sys_rst;
    fifo_nonempty = (count_q != '0);
    force_fb      = fifo_nonempty &&
                    ((starve_q == STARVE_MAX) || (count_q >= NEAR_FULL));
    predict_gnt   = 1'b0;
    feedback_gnt  = 1'b0;
    if (active) begin
      if (force_fb) begin
        feedback_gnt = 1'b1;
      end else if (IFPA_predict_req) begin
        predict_gnt = 1'b1;
      end else if (fifo_nonempty) begin
        feedback_gnt = 1'b1;
      end
    end
  end

  // A push is judged against the registered full flag only, so a push while
  // full is dropped even if the head pops in the same cycle.
  always_comb begin
    push = ROBPA_fb_valid && !full_q && active;
    pop  = feedback_gnt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (active) begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push) begin
        mem_d[tail_q] = '{pc: ROBPA_fb_pc, taken: ROBPA_fb_taken};
        tail_d        = tail_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Starve tracks consecutive fetch wins over a waiting queue.
      if (!fifo_nonempty || feedback_gnt) begin
        starve_d = '0;
      end else if (predict_gnt && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end

    full_d = (count_d == DEPTH_C);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      full_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      full_q   <= full_d;
    end
  end

  // Queue storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge Sys_clk) begin
    mem_q <= mem_d;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    head_entry          = mem_q[head_q];
    PAPD_predict_en     = predict_gnt;
    PAIF_predict_valid  = predict_gnt;
    PAIF_predict_result = predict_gnt & PDPA_predict_result;
    PAPD_pc             = IFPA_pc;
    PAPD_feedback_en    = feedback_gnt;
    PAPD_feedback_pc    = fifo_nonempty ? head_entry.pc : '0;
    PAPD_branch_result  = fifo_nonempty ? head_entry.taken : 1'b0;
    PAROB_fb_full       = full_q;
  end

endmodule

// File: tb/tb_predictor_update_arbiter.sv
module tb_predictor_update_arbiter;

  localparam int AW     = 32;
  localparam int DEPTH  = 8;
  localparam int LIMIT  = 4;

  logic          Sys_clk = 1'b0;
  logic          Sys_rst;
  logic          Sys_rdy;
  logic          IFPA_predict_req;
  logic [AW-1:0] IFPA_pc;
  logic          PAIF_predict_valid;
  logic          PAIF_predict_result;
  logic          ROBPA_fb_valid;
  logic [AW-1:0] ROBPA_fb_pc;
  logic          ROBPA_fb_taken;
  logic          PAROB_fb_full;
  logic          PAPD_predict_en;
  logic [AW-1:0] PAPD_pc;
  logic          PDPA_predict_result;
  logic          PAPD_feedback_en;
  logic [AW-1:0] PAPD_feedback_pc;
  logic          PAPD_branch_result;

  predictor_update_arbiter #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG(3), .STARVE_LIMIT(LIMIT)
  ) dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .IFPA_predict_req(IFPA_predict_req), .IFPA_pc(IFPA_pc),
    .PAIF_predict_valid(PAIF_predict_valid), .PAIF_predict_result(PAIF_predict_result),
    .ROBPA_fb_valid(ROBPA_fb_valid), .ROBPA_fb_pc(ROBPA_fb_pc),
    .ROBPA_fb_taken(ROBPA_fb_taken), .PAROB_fb_full(PAROB_fb_full),
    .PAPD_predict_en(PAPD_predict_en), .PAPD_pc(PAPD_pc),
    .PDPA_predict_result(PDPA_predict_result),
    .PAPD_feedback_en(PAPD_feedback_en), .PAPD_feedback_pc(PAPD_feedback_pc),
    .PAPD_branch_result(PAPD_branch_result)
  );

  always #5 Sys_clk = ~Sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed output bundle, same field order as exp_vec().
  logic [69:0] obs;
  assign obs = {PAPD_predict_en, PAIF_predict_valid, PAIF_predict_result,
                PAPD_feedback_en, PAPD_feedback_pc, PAPD_branch_result,
                PAROB_fb_full, PAPD_pc};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] pc;
    logic          taken;
  } ent_t;

  ent_t mq[$];
  int   m_starve = 0;
  bit   m_full   = 1'b0;

  function automatic void m_grant(output bit pr, output bit fb);
    bit frc;
    pr = 1'b0;
    fb = 1'b0;
    if (!Sys_rst && Sys_rdy) begin
      frc = (mq.size() != 0) && (m_starve == LIMIT || mq.size() >= DEPTH - 1);
      if (frc)                   fb = 1'b1;
      else if (IFPA_predict_req) pr = 1'b1;
      else if (mq.size() != 0)   fb = 1'b1;
    end
  endfunction

  function automatic logic [69:0] exp_vec();
    bit   pr, fb;
    ent_t h;
    m_grant(pr, fb);
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return {pr, pr, pr & PDPA_predict_result, fb, h.pc, h.taken, m_full, IFPA_pc};
  endfunction

  function automatic void model_update();
    bit pr, fb, psh;
    if (Sys_rst) begin
      mq.delete();
      m_starve = 0;
      m_full   = 1'b0;
    end else if (Sys_rdy) begin
      m_grant(pr, fb);
      psh = ROBPA_fb_valid && !m_full;
      if (mq.size() == 0 || fb) m_starve = 0;
      else if (pr)              m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (fb)  void'(mq.pop_front());
      if (psh) mq.push_back('{pc: ROBPA_fb_pc, taken: ROBPA_fb_taken});
      m_full = (mq.size() == DEPTH);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit rdy, input bit rst, input bit req,
                       input logic [AW-1:0] pc, input bit pres,
                       input bit fbv, input logic [AW-1:0] fpc, input bit ft);
    Sys_rdy             = rdy;
    Sys_rst             = rst;
    IFPA_predict_req    = req;
    IFPA_pc             = pc;
    PDPA_predict_result = pres;
    ROBPA_fb_valid      = fbv;
    ROBPA_fb_pc         = fpc;
    ROBPA_fb_taken      = ft;
    #1;
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    model_update();
    @(negedge Sys_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 1, 1, $urandom, 1, 1, $urandom, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, $urandom, 1, 1, $urandom, 1);
      if (PAPD_predict_en !== 1'b0 || PAPD_feedback_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_grants: pe=%b fe=%b expected 0 0", PAPD_predict_en, PAPD_feedback_en);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_vec: got %h expected %h", obs, exp_vec());
      end
      n_cmp++;
      tick();
    end
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_single_push();
    drive(1, 0, 0, $urandom, 0, 1, 32'h104, 1);
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL single_push_cyc0: got %h expected %h", obs, exp_vec());
    end
    n_cmp++;
    tick();
    drive(1, 0, 0, $urandom, 0, 0, 32'h0, 0);
    if (PAPD_feedback_en !== 1'b1 || PAPD_feedback_pc !== 32'h104 || PAPD_branch_result !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push_update: fe=%b pc=%h br=%b expected 1 00000104 1",
               PAPD_feedback_en, PAPD_feedback_pc, PAPD_branch_result);
    end
    n_cmp++;
    tick();
    drive(1, 0, 0, $urandom, 0, 0, 32'h0, 0);
    if (PAPD_feedback_en !== 1'b0 || PAPD_feedback_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL single_push_empty: fe=%b pc=%h expected 0 00000000",
               PAPD_feedback_en, PAPD_feedback_pc);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_starve();
    int pat[8] = '{1, 1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 32'h4000 + i, $urandom_range(0, 1), (i == 0), 32'h200, 0);
      if (PAIF_predict_valid !== pat[i][0] || PAPD_feedback_en !== !pat[i][0]) begin
        n_fail++;
        $display("FAIL starve_pattern cyc%0d: pv=%b fe=%b expected pv=%0d", i,
                 PAIF_predict_valid, PAPD_feedback_en, pat[i]);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL starve_vec cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] next_pc;
    next_pc = 32'h1000;
    for (int i = 0; i < 24; i++) begin
      drive(1, 0, (i < 12), $urandom, $urandom_range(0, 1),
            (i < 12), 32'h1000 + 4 * i, i[0]);
      if (PAPD_predict_en && PAPD_feedback_en) begin
        n_fail++;
        $display("FAIL b2b_exclusive cyc%0d: both enables high", i);
      end
      n_cmp++;
      if (PAROB_fb_full !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_full cyc%0d: full=%b expected 0", i, PAROB_fb_full);
      end
      n_cmp++;
      if (PAPD_feedback_en === 1'b1) begin
        if (PAPD_feedback_pc !== next_pc) begin
          n_fail++;
          $display("FAIL b2b_order: pc=%h expected %h", PAPD_feedback_pc, next_pc);
        end
        n_cmp++;
        next_pc = next_pc + 4;
      end
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_vec cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
      tick();
    end
    if (next_pc !== 32'h1030) begin
      n_fail++;
      $display("FAIL b2b_drained: next pc %h expected 00001030", next_pc);
    end
    n_cmp++;
  endtask

  task automatic test_rdy_low();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, $urandom, 0, 1, 32'h500 + 4 * i, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, $urandom, 1, 1, 32'h5f0, 0);
      if (PAPD_predict_en !== 1'b0 || PAPD_feedback_en !== 1'b0 || PAIF_predict_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rdy_low_grants cyc%0d: pe=%b fe=%b pv=%b expected 0 0 0", i,
                 PAPD_predict_en, PAPD_feedback_en, PAIF_predict_valid);
      end
      n_cmp++;
      tick();
    end
    drive(1, 0, 1, $urandom, 1, 0, 32'h0, 0);
    if (PAIF_predict_valid !== 1'b1 || PAIF_predict_result !== 1'b1 || PAPD_feedback_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL rdy_resume: pv=%b pr=%b head=%h expected 1 1 00000500",
               PAIF_predict_valid, PAIF_predict_result, PAPD_feedback_pc);
    end
    n_cmp++;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, $urandom, 0, 0, 32'h0, 0);
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rdy_drain cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (mq.size() < 5 && guard < 20) begin
      drive(1, 0, 1, $urandom, 0, 1, 32'h700 + 4 * guard, 0);
      tick();
      guard++;
    end
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL reset_mid_fill: queue never reached 5 entries");
    end
    n_cmp++;
    drive(1, 1, 1, $urandom, 1, 1, 32'h7f0, 1);
    if (PAPD_feedback_en !== 1'b0 || PAPD_predict_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_cycle: fe=%b pe=%b expected 0 0", PAPD_feedback_en, PAPD_predict_en);
    end
    n_cmp++;
    tick();
    drive(1, 0, 0, $urandom, 0, 0, 32'h0, 0);
    if (PAPD_feedback_en !== 1'b0 || PAROB_fb_full !== 1'b0 || PAPD_feedback_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: fe=%b full=%b head=%h expected 0 0 00000000",
               PAPD_feedback_en, PAROB_fb_full, PAPD_feedback_pc);
    end
    n_cmp++;
    drive(1, 0, 0, $urandom, 0, 1, 32'h3c0, 0);
    tick();
    drive(1, 0, 0, $urandom, 0, 0, 32'h0, 0);
    if (PAPD_feedback_en !== 1'b1 || PAPD_feedback_pc !== 32'h3c0 || PAPD_branch_result !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: fe=%b pc=%h br=%b expected 1 000003c0 0",
               PAPD_feedback_en, PAPD_feedback_pc, PAPD_branch_result);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 63) == 0),
            $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1));
      if (PAPD_predict_en && PAPD_feedback_en) begin
        n_fail++;
        $display("FAIL random_exclusive cyc%0d: both enables high", i);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_vec cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
      tick();
    end
  endtask

  initial begin
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge Sys_clk);
    test_reset();
    test_single_push();
    test_starve();
    test_back_to_back();
    test_rdy_low();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
